// File: rtl/i2s_tx_master.sv
// Philips I2S master transmitter: divides clk down to sck, generates ws and
// serialises one double-buffered stereo pair per frame, MSB first.
module i2s_tx_master #(
   parameter int DAT_WDTH = 24,
   parameter int SYS_WDTH = 32,
   parameter int CLK_DIV  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DAT_WDTH-1:0] left_in,
   input  logic [DAT_WDTH-1:0] right_in,
   output logic                sck,
   output logic                ws,
   output logic                sd,
   output logic                underrun
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FRM_W = 2 * SYS_WDTH;
   localparam int BIT_W = $clog2(FRM_W);

   logic                run;
   logic [DIV_W-1:0]    div_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [BIT_W-1:0]    bit_nxt;
   logic [FRM_W-1:0]    shreg;
   logic [FRM_W-1:0]    shreg_nxt;
   logic [FRM_W-1:0]    frame_load;
   logic [SYS_WDTH-1:0] left_slot;
   logic [SYS_WDTH-1:0] right_slot;
   logic [DAT_WDTH-1:0] hold_left;
   logic [DAT_WDTH-1:0] hold_right;
   logic                full;
   logic                div_wrap;
   logic                fall;
   logic                load;

   // Handshake: a pair transfers on a clk edge where in_valid && in_ready;
   // the producer holds in_valid and data stable until that edge.
   assign in_ready = ~full;

   always_comb begin
      div_wrap   = run && (div_cnt == DIV_W'(CLK_DIV - 1));
      fall       = div_wrap && sck;
      bit_nxt    = (bit_cnt == BIT_W'(FRM_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
      load       = fall && (bit_nxt == '0);
      left_slot  = '0;
      right_slot = '0;
      left_slot[SYS_WDTH-1 -: DAT_WDTH]  = hold_left;
      right_slot[SYS_WDTH-1 -: DAT_WDTH] = hold_right;
      frame_load = full ? {left_slot, right_slot} : '0;
      shreg_nxt  = (bit_nxt == '0) ? frame_load : {shreg[FRM_W-2:0], 1'b0};
   end

   // run delays the divider by one clk so the first rise lands CLK_DIV
   // cycles after the first edge out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run      <= 1'b0;
         div_cnt  <= '0;
         sck      <= 1'b0;
         bit_cnt  <= BIT_W'(FRM_W - 1);
         shreg    <= '0;
         ws       <= 1'b0;
         sd       <= 1'b0;
         underrun <= 1'b0;
      end else begin
         run      <= 1'b1;
         underrun <= 1'b0;
         if (run) begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
         end
         if (div_wrap) begin
            sck <= ~sck;
         end
         if (fall) begin
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
            sd      <= shreg_nxt[FRM_W-1];
            ws      <= (bit_nxt >= BIT_W'(SYS_WDTH - 1)) && (bit_nxt <= BIT_W'(FRM_W - 2));
            if (bit_nxt == '0) begin
               underrun <= ~full;
            end
         end
      end
   end

   // Accept requires !full and a load only drains when full, so the two
   // never compete for the holding register in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full       <= 1'b0;
         hold_left  <= '0;
         hold_right <= '0;
      end else if (in_valid && !full) begin
         full       <= 1'b1;
         hold_left  <= left_in;
         hold_right <= right_in;
      end else if (load) begin
         full       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master: default build plus a CLK_DIV=1, 16-bit
// build, with a loopback I2S receiver model sampling sd/ws on sck rises.
module tb_i2s_tx_master;

   logic        clk;
   logic        rst_n;
   logic        v0, rdy0, sck0, ws0, sd0, und0;
   logic [23:0] l0, r0;
   logic        v1, rdy1, sck1, ws1, sd1, und1;
   logic [15:0] l1, r1;

   int vectors     = 0;
   int miscompares = 0;
   int edge_n      = -1;
   int acc_cnt     = 0;
   int rdy_hi_cnt  = 0;
   int und_cnt0    = 0;
   int und_cnt1    = 0;
   int n_val       = 0;
   logic stream_en = 1'b0;
   logic sd_any    = 1'b0;

   logic        p_sck[2];
   logic        p_ws[2];
   logic        in_frame[2];
   int          cnt[2];
   logic [63:0] sh_d[2];
   logic [63:0] sh_w[2];
   logic [63:0] rxd0_q[$], rxw0_q[$], rxd1_q[$], rxw1_q[$];
   logic [63:0] exp_q[$];

   i2s_tx_master dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
      .left_in(l0), .right_in(r0), .sck(sck0), .ws(ws0), .sd(sd0), .underrun(und0)
   );

   i2s_tx_master #(.DAT_WDTH(16), .SYS_WDTH(16), .CLK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
      .left_in(l1), .right_in(r1), .sck(sck1), .ws(ws1), .sd(sd1), .underrun(und1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic rx_clear();
      for (int i = 0; i < 2; i++) begin
         p_sck[i] = 1'b0; p_ws[i] = 1'b0; in_frame[i] = 1'b0;
         cnt[i] = 0; sh_d[i] = '0; sh_w[i] = '0;
      end
      rxd0_q.delete(); rxw0_q.delete(); rxd1_q.delete(); rxw1_q.delete();
   endtask

   // Loopback receiver: samples on sck rise; ws 1->0 seen at a rise means
   // the next rise carries the left MSB.
   task automatic rx_step(input int sel, input logic c, input logic w, input logic d, input int s);
      if (!p_sck[sel] && c) begin
         if (in_frame[sel]) begin
            sh_d[sel] = {sh_d[sel][62:0], d};
            sh_w[sel] = {sh_w[sel][62:0], w};
            cnt[sel]++;
            if (cnt[sel] == 2 * s) begin
               if (sel == 0) begin rxd0_q.push_back(sh_d[0]); rxw0_q.push_back(sh_w[0]); end
               else          begin rxd1_q.push_back(sh_d[1]); rxw1_q.push_back(sh_w[1]); end
               in_frame[sel] = 1'b0;
            end
         end
         if (p_ws[sel] && !w) begin
            in_frame[sel] = 1'b1; cnt[sel] = 0; sh_d[sel] = '0; sh_w[sel] = '0;
         end
         p_ws[sel] = w;
      end
      p_sck[sel] = c;
   endtask

   // driver tasks
   task automatic tick();
      logic acc0;
      acc0 = v0 && rdy0;
      @(posedge clk);
      #1;
      edge_n++;
      if (acc0) begin
         acc_cnt++;
         if (stream_en) begin
            n_val++;
            l0 = 24'(n_val);
            r0 = 24'(n_val);
         end
      end
      if (rdy0) rdy_hi_cnt++;
      if (und0) und_cnt0++;
      if (und1) und_cnt1++;
      sd_any = sd_any | sd0;
      rx_step(0, sck0, ws0, sd0, 32);
      rx_step(1, sck1, ws1, sd1, 16);
   endtask

   task automatic run_to(input int e);
      while (edge_n < e) tick();
   endtask

   task automatic send0(input logic [23:0] l, input logic [23:0] r);
      int g;
      g = 0;
      v0 = 1'b1; l0 = l; r0 = r;
      while (!rdy0 && g < 2000) begin tick(); g++; end
      tick();
      v0 = 1'b0;
   endtask

   task automatic send1(input logic [15:0] l, input logic [15:0] r);
      int g;
      g = 0;
      v1 = 1'b1; l1 = l; r1 = r;
      while (!rdy1 && g < 2000) begin tick(); g++; end
      tick();
      v1 = 1'b0;
   endtask

   task automatic wait_rx(input int sel, output logic [63:0] d, output logic [63:0] w);
      int g;
      g = 0;
      while (((sel == 0) ? rxd0_q.size() : rxd1_q.size()) == 0 && g < 3000) begin
         tick(); g++;
      end
      d = '0; w = '0;
      if (((sel == 0) ? rxd0_q.size() : rxd1_q.size()) == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL rx_timeout: observed no frame on dut%0d expected one frame", sel);
      end else if (sel == 0) begin
         d = rxd0_q.pop_front(); w = rxw0_q.pop_front();
      end else begin
         d = rxd1_q.pop_front(); w = rxw1_q.pop_front();
      end
   endtask

   // scoreboard: expected frames queued before each receive
   task automatic expect_frame(input int sel, input string tag, input logic [63:0] e);
      logic [63:0] d, w, x;
      exp_q.push_back(e);
      wait_rx(sel, d, w);
      x = exp_q.pop_front();
      chk(tag, d, x);
   endtask

   initial begin
      logic [63:0] d, w;
      int s_acc, s_rdy, s_und, g, e1, e2;
      logic sa;

      rst_n = 1'b0;
      v0 = 1'b0; l0 = '0; r0 = '0;
      v1 = 1'b0; l1 = '0; r1 = '0;
      rx_clear();
      repeat (3) @(posedge clk);
      #1;
      chk_bit("rst_sck", sck0, 1'b0);
      chk_bit("rst_ws", ws0, 1'b0);
      chk_bit("rst_sd", sd0, 1'b0);
      chk_bit("rst_in_ready", rdy0, 1'b1);
      chk_bit("rst_underrun", und0, 1'b0);
      chk_bit("rst_in_ready_sweep", rdy1, 1'b1);

      // reset defaults, nothing offered
      @(negedge clk);
      rst_n = 1'b1;
      edge_n = -1; und_cnt0 = 0; sd_any = 1'b0;
      tick();
      chk_bit("sck0_e0", sck0, 1'b0);
      chk_bit("sck1_e0", sck1, 1'b0);
      tick();
      chk_bit("sck1_rise_e1", sck1, 1'b1);
      tick();
      chk_bit("sck1_fall_e2", sck1, 1'b0);
      chk_bit("und1_e2", und1, 1'b1);
      run_to(3);
      chk_bit("sck0_e3", sck0, 1'b0);
      tick();
      chk_bit("sck0_rise_e4", sck0, 1'b1);
      run_to(7);
      chk_bit("sck0_e7", sck0, 1'b1);
      chk_bit("und0_e7", und0, 1'b0);
      tick();
      chk_bit("sck0_fall_e8", sck0, 1'b0);
      chk_bit("und0_e8", und0, 1'b1);
      tick();
      chk_bit("und0_e9", und0, 1'b0);
      run_to(520);
      chk_bit("und0_e520", und0, 1'b1);
      chk("und0_count_idle", 64'(und_cnt0), 64'd2);
      chk_bit("sd_idle_zero", sd_any, 1'b0);

      // single pair
      v0 = 1'b1; l0 = 24'hA5F00F; r0 = 24'h5A0FF0;
      tick();
      v0 = 1'b0;
      chk_bit("ready_low_after_accept", rdy0, 1'b0);
      chk("accept_count_single", 64'(acc_cnt), 64'd1);
      run_to(1031);
      chk_bit("ready_before_load", rdy0, 1'b0);
      tick();
      chk_bit("ready_after_load", rdy0, 1'b1);
      chk_bit("no_underrun_loaded", und0, 1'b0);
      wait_rx(0, d, w);
      chk("zero_frame", d, 64'h0);
      chk("ws_pattern_zero_frame", w, 64'h00000001_FFFFFFFE);
      wait_rx(0, d, w);
      chk("single_pair_frame", d, 64'hA5F00F00_5A0FF000);
      chk("ws_pattern_pair", w, 64'h00000001_FFFFFFFE);
      chk("pair_frame_end_edge", 64'(edge_n), 64'd1540);

      // back-to-back streaming
      n_val = 1; l0 = 24'd1; r0 = 24'd1; v0 = 1'b1; stream_en = 1'b1;
      s_acc = acc_cnt; s_rdy = rdy_hi_cnt; s_und = und_cnt0;
      for (int k = 1; k <= 4; k++) begin
         expect_frame(0, "stream_frame", {24'(k), 8'h00, 24'(k), 8'h00});
      end
      chk("stream_accepts", 64'(acc_cnt - s_acc), 64'd5);
      chk("stream_ready_high_cycles", 64'(rdy_hi_cnt - s_rdy), 64'd4);
      chk("stream_underruns", 64'(und_cnt0 - s_und), 64'd0);

      // underrun and resume
      v0 = 1'b0; stream_en = 1'b0;
      s_und = und_cnt0;
      expect_frame(0, "last_streamed_frame", {24'd5, 8'h00, 24'd5, 8'h00});
      run_to(4105);
      send0(24'd6, 24'd6);
      chk_bit("ready_low_resume", rdy0, 1'b0);
      expect_frame(0, "underrun_frame", 64'h0);
      expect_frame(0, "resume_frame", {24'd6, 8'h00, 24'd6, 8'h00});
      chk("underrun_once", 64'(und_cnt0 - s_und), 64'd1);

      // reset mid-frame with holding register full
      run_to(5129);
      send0(24'h123456, 24'h654321);
      run_to(5450);
      chk_bit("ws_bit40_pre_reset", ws0, 1'b1);
      chk_bit("full_pre_reset", rdy0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_bit("async_rst_sck", sck0, 1'b0);
      chk_bit("async_rst_ws", ws0, 1'b0);
      chk_bit("async_rst_sd", sd0, 1'b0);
      chk_bit("async_rst_in_ready", rdy0, 1'b1);
      chk_bit("async_rst_underrun", und0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rx_clear();
      edge_n = -1; und_cnt0 = 0; sd_any = 1'b0;
      tick();
      chk_bit("post_rst_ready", rdy0, 1'b1);
      run_to(8);
      chk_bit("post_rst_underrun", und0, 1'b1);
      run_to(520);
      chk_bit("post_rst_zero_frame", sd_any, 1'b0);
      chk("post_rst_underrun_count", 64'(und_cnt0), 64'd2);

      // parameter sweep build: CLK_DIV=1, 16-bit slots
      g = 0;
      while (!und1 && g < 200) begin tick(); g++; end
      chk_bit("sweep_load_seen", und1, 1'b1);
      rxd1_q.delete(); rxw1_q.delete();
      send1(16'hA50F, 16'h5AF0);
      chk_bit("sweep_ready_low", rdy1, 1'b0);
      wait_rx(1, d, w);
      chk("sweep_zero_frame", d, 64'h0);
      chk("sweep_ws_pattern", w, 64'h00000000_0001FFFE);
      wait_rx(1, d, w);
      chk("sweep_pair_frame", d, 64'h00000000_A50F5AF0);
      g = 0;
      while (!und1 && g < 200) begin tick(); g++; end
      e1 = edge_n;
      tick();
      g = 0;
      while (!und1 && g < 200) begin tick(); g++; end
      e2 = edge_n;
      chk("sweep_frame_cycles", 64'(e2 - e1), 64'd64);
      sa = sck1;
      tick();
      chk_bit("sweep_sck_toggle", sck1, ~sa);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/i2s_tx_master.md
# i2s_tx_master

I2S master transmitter that generates `sck`, `ws` and `sd` from a system clock and serialises stereo sample pairs supplied over a valid/ready handshake. It sits directly upstream of the I2S receive slave, either in loopback or across the board to a codec/peer. Frames are standard Philips I2S: `ws` low is the left slot, data is MSB-first, and there is a one-bit delay after each `ws` transition. The block double-buffers one sample pair so the producer has a full frame time to supply the next one.

## Interface
- `DAT_WDTH`, 24: sample width per channel.
- `SYS_WDTH`, 32: slot width in `sck` periods; must be ≥ `DAT_WDTH`.
- `CLK_DIV`, 4: `clk` cycles per `sck` half-period; must be ≥ 1. `sck` period is 2·`CLK_DIV` `clk` cycles.

Ports:
- `clk` input 1: system clock. This is the single clock of the block.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: a sample pair is offered.
- `in_ready` output 1: the holding register is empty.
- `left_in` input `DAT_WDTH`: left sample.
- `right_in` input `DAT_WDTH`: right sample.
- `sck` output 1: I2S bit clock, registered.
- `ws` output 1: word select, registered; 0 means left.
- `sd` output 1: serial data, registered; changes only on falling `sck`.
- `underrun` output 1: one-`clk` pulse when a frame starts with no data available.

## Operation
- **Divider.** `div_cnt` counts 0..`CLK_DIV`-1 and wraps. On each wrap, `sck` toggles. Toggling 0→1 is a rise; toggling 1→0 is a fall.
- **Bit counter.** `bit_cnt` covers 0..2·`SYS_WDTH`-1 and advances, with wrap, only on `sck` falls. Values 0..`SYS_WDTH`-1 are the left slot; the remainder is the right slot.
- **`ws` generation.** On each fall, `ws` is updated from the new `bit_cnt`:
  - `ws` = 1 for `bit_cnt` in [`SYS_WDTH`-1, 2·`SYS_WDTH`-2].
  - `ws` = 0 otherwise.
  - As a result, `ws` leads each slot's MSB by one `sck` period.
- **Frame load.** On the fall where `bit_cnt` becomes 0, the 2·`SYS_WDTH`-bit shift register loads:
  - `{left, zeros(SYS_WDTH-DAT_WDTH), right, zeros(SYS_WDTH-DAT_WDTH)}` from the holding register.
  - If the holding register is empty, it loads all zeros and `underrun` pulses for that `clk` cycle.
- **Shifting.** On every other fall, the shift register shifts left by one. `sd` = shift register MSB after each update.
- **Holding register and handshake:**
  - On `in_valid`&&`in_ready`, `left_in`/`right_in` are captured and the register becomes full.
  - `in_ready` = !full, registered.
  - The producer holds `in_valid` and data stable until accepted.
  - A frame load empties the holding register.
  - Because `in_ready` is low while full, accept and transfer can never occur in the same cycle.
- **Repeated offers.** At most one pair is accepted per frame once the holding register fills; further offers stall until the next frame load.
- **Reset.** Asserting `rst_n` low at any time, including mid-frame, immediately returns all state to reset values and discards held data. No partial frame is completed.

## Timing
- **Reset values:**
  - `sck`=0, `ws`=0, `sd`=0, `in_ready`=1, `underrun`=0.
  - `div_cnt`=0, `bit_cnt`=2·`SYS_WDTH`-1, shift register 0, holding register empty.
- **After reset release** (cycle 0 = first `clk` edge with `rst_n` high):
  - First `sck` rise at cycle `CLK_DIV`.
  - First fall at cycle 2·`CLK_DIV`. This fall performs the first frame load.
  - `sd` presents the left MSB from that fall onward.
- **Handshake latency:**
  - `in_ready` falls the cycle after acceptance.
  - `in_ready` rises the cycle after the frame load that consumes the pair.
- **Input to wire.** An accepted pair reaches `sd` at the next frame load. End-to-end latency is at most one frame plus one `sck` period.
- **Stable sampling.** `sd` and `ws` change only in the cycle of a `sck` fall, so both are stable across every rise.
- **Frame length.** One frame = 2·`SYS_WDTH`·2·`CLK_DIV` `clk` cycles; with defaults this is 512.

## Test plan
- **Reset defaults.** Apply reset, release, and offer nothing.
  - Outputs show the reset values.
  - `sck` first rises at cycle 4 and falls at cycle 8 (defaults).
  - `underrun` pulses at cycle 8 and again every 512 cycles.
  - `sd` stays 0.
- **Single pair.** Send one pair with left=0xA5F00F, right=0x5A0FF0.
  - Sampling `sd` on each `sck` rise over the next frame yields 0xA5F00F00 then 0x5A0FF000.
  - `ws` falls one `sck` before the left MSB and rises one `sck` before the right MSB.
- **Back-to-back streaming.**
  - Hold `in_valid` high with an incrementing left=right=n.
  - Exactly one accept occurs per frame and `in_ready` is low between accepts.
  - There is no `underrun` after the first frame.
  - A received-frame check (I2S receive slave in loopback) yields left=right=n in sequence.
- **Underrun.**
  - Stop feeding for one frame: an all-zero frame is sent and `underrun` pulses exactly once.
  - Resume feeding: the next frame carries the new pair.
- **Reset mid-frame.**
  - Assert `rst_n` low at `bit_cnt`=40 with the holding register full.
  - Outputs are at reset values in the same cycle, asynchronously.
  - After release, the first frame is zeros and `underrun` pulses, confirming the held data was discarded.
- **Parameter sweep.**
  - With `CLK_DIV`=1, `SYS_WDTH`=`DAT_WDTH`=16: `sck` toggles every `clk`, a frame lasts 64 cycles, and the single-pair scenario passes.
